button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
// - N-channel push-button front end for the stopwatch: synchroniser, debouncer
//   and edge/hold event generator per channel.
// - Generalises the two-flop synchroniser: configurable sync depth, channel count,
//   input polarity, and debounce filtering.
// - Emits one-cycle press/release/hold pulses for the control FSM (start/stop, lap,
//   long-press clear).
// - Sits directly behind the board pins; all outputs are in the clk domain.
// PARAMETERS
// - N_BTN            4       number of independent button channels
// - SYNC_STAGES      2       synchroniser flops per channel (>=2)
// - DEBOUNCE_CYCLES  500000  consecutive mismatching cycles before the stable level flips (>=1)
// - HOLD_CYCLES      0       cycles held after a press before btn_hold fires; 0 disables hold
// - ACTIVE_LOW       0       1: a pin reading 0 means pressed (input inverted after sync)
// - localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1), HLD_W = $clog2(HOLD_CYCLES+1) (min 1)
// PORTS
// - clk          in   1      system clock
// - rst_n        in   1      asynchronous, active-low reset
// - btn_raw      in   N_BTN  asynchronous button pins
// - btn_level    out  N_BTN  debounced level, 1 = pressed
// - btn_press    out  N_BTN  1-cycle pulse on debounced 0->1
// - btn_release  out  N_BTN  1-cycle pulse on debounced 1->0
// - btn_hold     out  N_BTN  1-cycle pulse, once per press, after HOLD_CYCLES held
// BEHAVIOUR
// - Reset (rst_n=0, async assert): all sync flops, counters and outputs = 0.
//   - Sync flops reset to 0 regardless of ACTIVE_LOW; inversion is applied after the chain.
//   - Deassertion is taken synchronously by the design's reset source.
// - Channels are fully independent; no cross-channel priority or interaction.
// - Sync: raw -> SYNC_STAGES cascaded flops; s = last flop ^ ACTIVE_LOW.
// - Debounce, per channel, state = stable bit + cnt[CNT_W]:
//   - s == stable: cnt <= 0. Any glitch restarts the count.
//   - s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
//   - s != stable otherwise: cnt <= cnt+1.
// - Latency: a clean raw change appears on btn_level exactly SYNC_STAGES+DEBOUNCE_CYCLES
//   edges after the first edge that samples it.
// - Filtering: pulses or gaps shorter than DEBOUNCE_CYCLES cycles (after sync) never
//   change btn_level.
// - btn_press / btn_release: registered, asserted on the same edge btn_level changes,
//   high for exactly 1 cycle. Never both high on the same channel.
// - Hold (HOLD_CYCLES>0):
//   - hld cleared on the press edge; increments each edge while btn_level=1, saturating
//     at HOLD_CYCLES.
//   - btn_hold pulses on the edge hld reaches HOLD_CYCLES, i.e. HOLD_CYCLES edges after
//     btn_press.
//   - Fires at most once per press.
//   - Release before that edge: no hold pulse; hld <= 0.
// - HOLD_CYCLES=0: btn_hold tied 0, hold counter not built.
// - Button held through reset: after rst_n rises it is debounced like a new press, and
//   btn_press fires at the normal latency.
// - Reset mid-debounce or mid-hold: counts lost; no pulse is emitted for the interrupted
//   event.
// - DEBOUNCE_CYCLES=1: stable follows s with one edge of delay (pure sync + edge detect).
// - Illegal parameters (SYNC_STAGES<2, DEBOUNCE_CYCLES<1) are rejected at elaboration
//   with $error.
// STRUCTURE
// - Sub-module button_channel: sync chain, debounce counter, edge and hold logic for one
//   channel; the top instantiates it N_BTN times via generate.
// - No typedefs needed. Shared package btn_pkg holds DEF_DEBOUNCE_CYCLES (10 ms @ 50 MHz)
//   and DEF_HOLD_CYCLES (1 s @ 50 MHz) for stopwatch-wide use.
// - Registers only: no RAM, no combinational path from btn_raw to any output.
// TESTING  (bench params: N_BTN=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10,
//          ACTIVE_LOW=0)
// - Reset: rst_n=0 with btn_raw=2'b11 toggling
//   -> all outputs 0 while low, and asserted with no clk running.
// - Clean press: raw[0] 0->1 held 20 cycles
//   -> btn_level[0]=1 and btn_press[0]=1 exactly 6 edges after first sample; press is
//   1 cycle wide.
// - Bounce: raw[0] pulses high 3 cycles, low 1, high 3
//   -> no level change; then held high -> press 6 edges after final rise.
// - Hold: raw[1] held 30 cycles
//   -> btn_hold[1] 10 edges after btn_press[1], single pulse.
//   Release at 8 cycles instead -> no hold, btn_release[1] pulse.
// - Independence: both channels pressed with a 2-cycle offset
//   -> press pulses 2 cycles apart, no cross-talk.
// - Mid-op reset + ACTIVE_LOW=1 rerun:
//   - rst_n low during hold count -> no hold pulse.
//   - Pin held 0 across reset release -> btn_press 6 edges after release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the stopwatch push-button front end.
package btn_pkg;

   // 10 ms of debounce at 50 MHz
   localparam int DEF_DEBOUNCE_CYCLES = 500_000;
   // 1 s long-press threshold at 50 MHz
   localparam int DEF_HOLD_CYCLES     = 50_000_000;

endpackage : btn_pkg

// File: rtl/button_channel.sv
// One push-button channel: synchroniser, debounce filter, press/release edge
// pulses and an optional once-per-press long-hold pulse.
module button_channel
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = 0,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0] arm_q, arm_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   s;

   // Synchroniser chain plus a parallel "armed" chain that marks when the
   // first post-reset pin sample has reached the end of the synchroniser.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
      arm_d  = {arm_q[SYNC_STAGES-2:0], 1'b1};
   end

   // Polarity is applied after the chain so the flops themselves always reset to 0.
   assign s = sync_q[SYNC_STAGES-1] ^ (ACTIVE_LOW != 0);

   // Debounce: the stable level flips only after DEBOUNCE_CYCLES consecutive
   // mismatching samples. The count is held off until the chain carries real
   // pin data, so an active-low pin does not read the reset zeros as a press.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (!arm_q[SYNC_STAGES-1] || s == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = s;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      press_d   =  stable_d & ~stable_q;
      release_d = ~stable_d &  stable_q;
   end

   // Channel state registers.
   // NOTE: non-blocking assignments in clocked blocks so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the sync chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         arm_q     <= '0;
         cnt_q     <= '0;
         stable_q  <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         arm_q     <= arm_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = stable_q;
   assign press_o   = press_q;
   assign release_o = release_q;

   if (HOLD_CYCLES > 0) begin : g_hold
      localparam int              HLD_W   = $clog2(HOLD_CYCLES + 1);
      localparam logic [HLD_W-1:0] HLD_MAX = HLD_W'(HOLD_CYCLES);

      logic [HLD_W-1:0] hld_q, hld_d;
      logic             hold_q, hold_d;

      // Hold counter: cleared on press/release, counts while pressed and
      // saturates, so the pulse fires exactly once per press.
      always_comb begin
         hld_d  = hld_q;
         hold_d = 1'b0;
         if (press_d || !stable_q) begin
            hld_d = '0;
         end else if (hld_q != HLD_MAX) begin
            hld_d  = hld_q + 1'b1;
            hold_d = (hld_q == HLD_MAX - 1'b1);
         end
      end

      // Hold registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            hld_q  <= '0;
            hold_q <= 1'b0;
         end else begin
            hld_q  <= hld_d;
            hold_q <= hold_d;
         end
      end

      assign hold_o = hold_q;
   end else begin : g_no_hold
      assign hold_o = 1'b0;
   end

endmodule : button_channel

// File: rtl/button_conditioner.sv
// N-channel push-button front end: one independent button_channel per pin.
// All outputs are registered in the clk domain.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = 0,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_hold
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("button_conditioner: SYNC_STAGES must be >= 2 (got %0d)", SYNC_STAGES);
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
      $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1 (got %0d)", DEBOUNCE_CYCLES);
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .HOLD_CYCLES    (HOLD_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (btn_raw[i]),
         .level_o  (btn_level[i]),
         .press_o  (btn_press[i]),
         .release_o(btn_release[i]),
         .hold_o   (btn_hold[i])
      );
   end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance
// driven by directed steps; expected pulses are queued at drive time with the
// cycle they must appear on and compared every cycle by a monitor.
module tb_button_conditioner;

   localparam int LAT  = 6;   // SYNC_STAGES + DEBOUNCE_CYCLES
   localparam int HOLD = 10;

   typedef enum int {EV_PRESS, EV_RELEASE, EV_HOLD} ev_kind_e;
   typedef struct {
      int       cyc;
      int       dut;
      int       ch;
      ev_kind_e kind;
   } ev_t;

   logic       clk = 1'b0;
   bit         clk_en = 1'b0;
   bit         mon_en = 1'b0;
   logic       rst_n0, rst_n1;
   logic [1:0] raw0, raw1;
   logic [1:0] lvl [2];
   logic [1:0] prs [2];
   logic [1:0] rls [2];
   logic [1:0] hld [2];
   logic [1:0] exp_lvl [2];
   ev_t        sb[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   always #5 if (clk_en) clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   button_conditioner #(.N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                        .HOLD_CYCLES(HOLD), .ACTIVE_LOW(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n0), .btn_raw(raw0),
      .btn_level(lvl[0]), .btn_press(prs[0]), .btn_release(rls[0]), .btn_hold(hld[0]));

   button_conditioner #(.N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                        .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .btn_raw(raw1),
      .btn_level(lvl[1]), .btn_press(prs[1]), .btn_release(rls[1]), .btn_hold(hld[1]));

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push(input int at, input int d, input int ch, input ev_kind_e k);
      ev_t e;
      e.cyc = at; e.dut = d; e.ch = ch; e.kind = k;
      sb.push_back(e);
   endtask

   // Change one pin; optionally queue the press/release it must produce.
   task automatic drive(input int d, input int ch, input logic v, input bit expect_evt);
      if (d == 0) raw0[ch] = v;
      else        raw1[ch] = v;
      if (expect_evt)
         push(cyc + LAT, d, ch, ((v ^ (d == 1)) === 1'b1) ? EV_PRESS : EV_RELEASE);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Assert reset on one instance; its pending events are lost with it.
   task automatic reset_dut(input int d);
      if (d == 0) rst_n0 = 1'b0;
      else        rst_n1 = 1'b0;
      exp_lvl[d] = 2'b00;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].dut == d) sb.delete(i);
   endtask

   // Monitor: every cycle, pulses must equal exactly the events due now.
   initial begin
      logic [1:0] ep, er, eh;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
               ep = 2'b00; er = 2'b00; eh = 2'b00;
               for (int i = sb.size() - 1; i >= 0; i--) begin
                  if (sb[i].cyc == cyc && sb[i].dut == d) begin
                     case (sb[i].kind)
                        EV_PRESS:   begin ep[sb[i].ch] = 1'b1; exp_lvl[d][sb[i].ch] = 1'b1; end
                        EV_RELEASE: begin er[sb[i].ch] = 1'b1; exp_lvl[d][sb[i].ch] = 1'b0; end
                        default:    eh[sb[i].ch] = 1'b1;
                     endcase
                     sb.delete(i);
                  end
               end
               check($sformatf("press d%0d cyc%0d", d, cyc),   prs[d], ep);
               check($sformatf("release d%0d cyc%0d", d, cyc), rls[d], er);
               check($sformatf("hold d%0d cyc%0d", d, cyc),    hld[d], eh);
               check($sformatf("level d%0d cyc%0d", d, cyc),   lvl[d], exp_lvl[d]);
            end
         end
      end
   end

   initial begin
      exp_lvl[0] = 2'b00;
      exp_lvl[1] = 2'b00;
      rst_n0 = 1'b0;
      rst_n1 = 1'b0;

      // Reset with no clock and pins toggling: outputs stay 0.
      raw0 = 2'b11; raw1 = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #3;
         for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_level d%0d step%0d", d, i),   lvl[d], 2'b00);
            check($sformatf("rst_press d%0d step%0d", d, i),   prs[d], 2'b00);
            check($sformatf("rst_release d%0d step%0d", d, i), rls[d], 2'b00);
            check($sformatf("rst_hold d%0d step%0d", d, i),    hld[d], 2'b00);
         end
         raw0 = ~raw0; raw1 = ~raw1;
      end

      // Clock on, still in reset; pins to idle, then release.
      clk_en = 1'b1;
      mon_en = 1'b1;
      wait_cyc(3);
      raw0 = 2'b00; raw1 = 2'b11;
      wait_cyc(3);
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      wait_cyc(6);

      // Clean press on ch0 held 20 cycles: press, hold after 10, release.
      drive(0, 0, 1'b1, 1'b1);
      push(cyc + LAT + HOLD, 0, 0, EV_HOLD);
      wait_cyc(20);
      drive(0, 0, 1'b0, 1'b1);
      wait_cyc(12);

      // Bounce: 3 high, 1 low, then high for good; only the final rise counts.
      drive(0, 0, 1'b1, 1'b0);
      wait_cyc(3);
      drive(0, 0, 1'b0, 1'b0);
      wait_cyc(1);
      drive(0, 0, 1'b1, 1'b1);
      wait_cyc(8);
      drive(0, 0, 1'b0, 1'b1);
      wait_cyc(12);

      // Long hold on ch1: single hold pulse 10 edges after press.
      drive(0, 1, 1'b1, 1'b1);
      push(cyc + LAT + HOLD, 0, 1, EV_HOLD);
      wait_cyc(30);
      drive(0, 1, 1'b0, 1'b1);
      wait_cyc(12);

      // Release after 8 cycles: no hold pulse.
      drive(0, 1, 1'b1, 1'b1);
      wait_cyc(8);
      drive(0, 1, 1'b0, 1'b1);
      wait_cyc(20);

      // Independence: both channels, 2-cycle offset.
      drive(0, 0, 1'b1, 1'b1);
      wait_cyc(2);
      drive(0, 1, 1'b1, 1'b1);
      wait_cyc(5);
      drive(0, 0, 1'b0, 1'b1);
      wait_cyc(2);
      drive(0, 1, 1'b0, 1'b1);
      wait_cyc(12);

      // Active-low instance: plain press with hold.
      drive(1, 1, 1'b0, 1'b1);
      push(cyc + LAT + HOLD, 1, 1, EV_HOLD);
      wait_cyc(15);
      drive(1, 1, 1'b1, 1'b1);
      wait_cyc(12);

      // Active-low: reset during the hold count, pin kept low across release.
      drive(1, 0, 1'b0, 1'b1);
      wait_cyc(LAT + 5);
      reset_dut(1);
      wait_cyc(3);
      rst_n1 = 1'b1;
      push(cyc + LAT, 1, 0, EV_PRESS);
      wait_cyc(LAT + 2);
      drive(1, 0, 1'b1, 1'b1);
      wait_cyc(20);

      // Every queued event must have been consumed.
      checks++;
      assert (sb.size() === 0) else begin
         errors++;
         $error("FAIL sb_empty observed=%0d expected=0", sb.size());
      end
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_button_conditioner
